cga_vga_doubler: RTL and testbench



---
 rtl/cga_dbl_pkg.sv | 12 +
 rtl/cga_dbl_linebuf.sv | 24 ++
 rtl/cga_vga_doubler.sv | 167 ++++++++++++++++
 tb/tb_cga_vga_doubler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_dbl_pkg.sv
// Shared widths and types for the CGA line doubler.
// Holds the default buffer geometry and the half-line index type.
package cga_dbl_pkg;
  localparam int LINE_MAX_DEF = 1024;
  localparam int ADDR_W       = $clog2(LINE_MAX_DEF);
  localparam int RGBI_W       = 4;

  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } half_e;
endpackage

// File: rtl/cga_dbl_linebuf.sv
// Ping-pong line buffer: 2 banks of 2**AW RGBI pixels, bank bit is addr MSB.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o sync read.
module cga_dbl_linebuf
  import cga_dbl_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW:0]       waddr_i,
  input  logic [RGBI_W-1:0] wdata_i,
  input  logic [AW:0]       raddr_i,
  output logic [RGBI_W-1:0] rdata_o
);
  logic [RGBI_W-1:0] mem_q [0:(2**(AW+1))-1];
  logic [RGBI_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cga_vga_doubler.sv
// 15.7 kHz -> 31 kHz line doubler: stores each CGA line, plays it twice.
// Ports: clk, reset, line_reset, video in; dbl_hsync, dbl_video, dbl_line out.
module cga_vga_doubler
  import cga_dbl_pkg::*;
#(
  parameter int LINE_MAX  = 1 << ADDR_W,
  parameter int IN_DIV    = 2,
  parameter int HSYNC_LEN = 80,
  parameter int PERIOD_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_reset,
  input  logic [RGBI_W-1:0] video,
  output logic              dbl_hsync,
  output logic [RGBI_W-1:0] dbl_video,
  output logic              dbl_line
);
  localparam int AW = $clog2(LINE_MAX);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(IN_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(IN_DIV - 1);
  localparam logic [DW-1:0] RDIV_LAST = DW'(IN_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(LINE_MAX);
  localparam logic [PERIOD_W-1:0] P_MAX  = '1;
  localparam logic [PERIOD_W-1:0] HS_LEN = PERIOD_W'(HSYNC_LEN);

  logic                active_q, active_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       wr_q, wr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [CW-1:0]       len_q, len_d;
  logic [PERIOD_W-1:0] half_prev_q, half_prev_d;
  logic [PERIOD_W-1:0] ht_q, ht_d;
  logic [CW-1:0]       rd_q, rd_d;
  logic [DW-1:0]       rdiv_q, rdiv_d;
  logic                vld_q, vld_d;
  logic                hsync_q, hsync_d;
  logic [RGBI_W-1:0]   video_q, video_d;
  half_e               half_q, half_d;

  logic                out_on, strobe, we, start1, start;
  logic [PERIOD_W-1:0] ht_e;
  logic [CW-1:0]       rd_e, len_e;
  logic [DW-1:0]       rdiv_e;
  logic                bank_e;
  logic [RGBI_W-1:0]   rdata;

  // The line_reset clock is cycle 0 of both the new input line and
  // half-line 0, so counters seen in that clock read as zero.
  assign out_on = active_q | line_reset;
  assign strobe = active_q & ~line_reset & (div_q == DIV_LAST);
  assign we     = strobe & (wr_q < CNT_MAX);
  assign start1 = active_q & ~line_reset & (half_q == HALF0)
                & (half_prev_q != '0) & (ht_q == half_prev_q);
  assign start  = line_reset | start1;
  assign ht_e   = start ? '0 : ht_q;
  assign rd_e   = start ? '0 : rd_q;
  assign rdiv_e = start ? '0 : rdiv_q;
  assign bank_e = line_reset ? wr_bank_q : rd_bank_q;
  assign len_e  = line_reset ? wr_q : len_q;

  cga_dbl_linebuf #(.AW(AW)) u_buf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({wr_bank_q, wr_q[AW-1:0]}),
    .wdata_i (video),
    .raddr_i ({bank_e, rd_e[AW-1:0]}),
    .rdata_o (rdata)
  );

  always_comb begin
    active_d    = active_q | line_reset;
    div_d       = div_q;
    wr_d        = wr_q;
    period_d    = period_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    len_d       = len_q;
    half_prev_d = half_prev_q;
    if (line_reset) begin
      div_d       = DW'(1);
      wr_d        = '0;
      period_d    = PERIOD_W'(1);
      wr_bank_d   = ~wr_bank_q;
      rd_bank_d   = wr_bank_q;
      len_d       = wr_q;
      half_prev_d = period_q >> 1;
    end else if (active_q) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (we) wr_d = wr_q + 1'b1;
      if (period_q != P_MAX) period_d = period_q + 1'b1;
    end
  end

  always_comb begin
    ht_d    = ht_q;
    rd_d    = rd_q;
    rdiv_d  = rdiv_q;
    hsync_d = out_on & (ht_e < HS_LEN);
    vld_d   = out_on & (rd_e < len_e);
    video_d = vld_q ? rdata : '0;
    if (out_on) begin
      ht_d   = (ht_e == P_MAX) ? ht_e : ht_e + 1'b1;
      rdiv_d = (rdiv_e == RDIV_LAST) ? '0 : rdiv_e + 1'b1;
      rd_d   = rd_e;
      if ((rdiv_e == RDIV_LAST) && (rd_e < len_e)) rd_d = rd_e + 1'b1;
    end
  end

  always_comb begin
    half_d = half_q;
    unique case (1'b1)
      line_reset: half_d = HALF0;
      start1:     half_d = HALF1;
      default:    half_d = half_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) half_q <= HALF0;
    else       half_q <= half_d;
  end

  always_comb begin
    dbl_line = (half_q == HALF1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= 1'b0;
      div_q       <= '0;
      wr_q        <= '0;
      period_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      len_q       <= '0;
      half_prev_q <= '0;
      ht_q        <= '0;
      rd_q        <= '0;
      rdiv_q      <= '0;
      vld_q       <= 1'b0;
      hsync_q     <= 1'b0;
      video_q     <= '0;
    end else begin
      active_q    <= active_d;
      div_q       <= div_d;
      wr_q        <= wr_d;
      period_q    <= period_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      len_q       <= len_d;
      half_prev_q <= half_prev_d;
      ht_q        <= ht_d;
      rd_q        <= rd_d;
      rdiv_q      <= rdiv_d;
      vld_q       <= vld_d;
      hsync_q     <= hsync_d;
      video_q     <= video_d;
    end
  end

  assign dbl_hsync = hsync_q;
  assign dbl_video = video_q;
endmodule

// File: tb/tb_cga_vga_doubler.sv
// Directed bench for cga_vga_doubler.
// Two instances: default depth and LINE_MAX=256 for saturation.
`timescale 1ns/1ps
module tb_cga_vga_doubler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_reset = 1'b0;
  logic [3:0] video = 4'h0;
  logic       hs_a, dl_a, hs_b, dl_b;
  logic [3:0] dv_a, dv_b;

  int errors = 0;
  int checks = 0;
  int off = 0;

  logic       cap_hs [0:1023];
  logic       cap_dl [0:1023];
  logic [3:0] cap_dv [0:1023];
  logic       cap_hsb [0:1023];
  logic       cap_dlb [0:1023];
  logic [3:0] cap_dvb [0:1023];

  always #5 clk = ~clk;

  cga_vga_doubler u_a (
    .clk        (clk),
    .reset      (reset),
    .line_reset (line_reset),
    .video      (video),
    .dbl_hsync  (hs_a),
    .dbl_video  (dv_a),
    .dbl_line   (dl_a)
  );

  cga_vga_doubler #(.LINE_MAX(256)) u_b (
    .clk        (clk),
    .reset      (reset),
    .line_reset (line_reset),
    .video      (video),
    .dbl_hsync  (hs_b),
    .dbl_video  (dv_b),
    .dbl_line   (dl_b)
  );

  // One clock: inputs applied just after posedge, outputs captured at negedge.
  // Sample k of a line sits at offset 2k+1 and carries k mod 16;
  // the line_reset clock carries 4'hA so a wrongly kept sample stands out.
  task automatic tick(input logic lr);
    line_reset = lr;
    if (lr) off = 0;
    video = lr ? 4'hA : 4'((off >> 1) & 15);
    @(negedge clk);
    if (off < 1024) begin
      cap_hs[off]  = hs_a;
      cap_dl[off]  = dl_a;
      cap_dv[off]  = dv_a;
      cap_hsb[off] = hs_b;
      cap_dlb[off] = dl_b;
      cap_dvb[off] = dv_b;
    end
    @(posedge clk);
    #1;
    off++;
  endtask

  task automatic run_line(input int len);
    tick(1'b1);
    repeat (len - 1) tick(1'b0);
  endtask

  function automatic void scan_hs(input int len, output int nr,
                                  output int r0, output int w0,
                                  output int r1, output int w1);
    logic prev;
    prev = 1'b0;
    nr = 0; r0 = -1; w0 = 0; r1 = -1; w1 = 0;
    for (int i = 0; i < len; i++) begin
      if (cap_hs[i] && !prev) begin
        nr++;
        if (nr == 1) r0 = i;
        else if (nr == 2) r1 = i;
      end
      if (cap_hs[i]) begin
        if (nr == 1) w0++;
        else if (nr == 2) w1++;
      end
      prev = cap_hs[i];
    end
  endfunction

  task automatic test_reset();
    int hi, nz;
    checks++;
    if (dv_a !== 4'h0) begin
      errors++; $display("FAIL reset_video: got %0h want 0", dv_a);
    end
    checks++;
    if (hs_a !== 1'b0) begin
      errors++; $display("FAIL reset_hsync: got %0b want 0", hs_a);
    end
    checks++;
    if (dl_a !== 1'b0) begin
      errors++; $display("FAIL reset_line: got %0b want 0", dl_a);
    end
    reset = 1'b0;
    off = 0;
    repeat (50) tick(1'b0);
    hi = 0; nz = 0;
    for (int i = 0; i < 50; i++) begin
      if (cap_hs[i] !== 1'b0) hi++;
      if (cap_dv[i] !== 4'h0) nz++;
    end
    checks++;
    if (hi !== 0) begin
      errors++; $display("FAIL idle_hsync: got %0d high clocks want 0", hi);
    end
    checks++;
    if (nz !== 0) begin
      errors++; $display("FAIL idle_video: got %0d lit clocks want 0", nz);
    end
  endtask

  task automatic test_startup();
    int nr, r0, w0, r1, w1, nz;
    run_line(912);
    scan_hs(912, nr, r0, w0, r1, w1);
    checks++;
    if (nr !== 1) begin
      errors++; $display("FAIL start_pulses: got %0d want 1", nr);
    end
    checks++;
    if (r0 !== 1 || w0 !== 80) begin
      errors++;
      $display("FAIL start_sync: got rise %0d width %0d want 1 80", r0, w0);
    end
    nz = 0;
    for (int i = 0; i < 912; i++) if (cap_dv[i] !== 4'h0) nz++;
    checks++;
    if (nz !== 0) begin
      errors++; $display("FAIL start_black: got %0d lit want 0", nz);
    end
    checks++;
    if (cap_dl[700] !== 1'b0) begin
      errors++; $display("FAIL start_line: got %0b want 0", cap_dl[700]);
    end
  endtask

  task automatic test_basic();
    int nr, r0, w0, r1, w1, m0, m1;
    run_line(912);
    scan_hs(912, nr, r0, w0, r1, w1);
    checks++;
    if (nr !== 2) begin
      errors++; $display("FAIL basic_pulses: got %0d want 2", nr);
    end
    checks++;
    if (r0 !== 1 || w0 !== 80) begin
      errors++;
      $display("FAIL basic_sync0: got rise %0d width %0d want 1 80", r0, w0);
    end
    checks++;
    if (r1 !== 457 || w1 !== 80) begin
      errors++;
      $display("FAIL basic_sync1: got rise %0d width %0d want 457 80", r1, w1);
    end
    m0 = 0; m1 = 0;
    for (int i = 2; i < 458; i++)
      if (cap_dv[i] === 4'((i - 2) & 15)) m0++;
    for (int i = 458; i < 912; i++)
      if (cap_dv[i] === 4'((i - 458) & 15)) m1++;
    checks++;
    if (m0 !== 456) begin
      errors++; $display("FAIL basic_half0: got %0d good want 456", m0);
    end
    checks++;
    if (m1 !== 454) begin
      errors++; $display("FAIL basic_half1: got %0d good want 454", m1);
    end
    checks++;
    if (cap_dl[1] !== 1'b0 || cap_dl[456] !== 1'b0) begin
      errors++;
      $display("FAIL basic_line0: got %0b%0b want 00", cap_dl[1], cap_dl[456]);
    end
    checks++;
    if (cap_dl[457] !== 1'b1 || cap_dl[911] !== 1'b1) begin
      errors++;
      $display("FAIL basic_line1: got %0b%0b want 11", cap_dl[457], cap_dl[911]);
    end
  endtask

  task automatic test_saturation();
    int m0, m1;
    logic [3:0] ex;
    run_line(912);
    m0 = 0; m1 = 0;
    for (int i = 2; i < 458; i++) begin
      ex = (i < 258) ? 4'((i - 2) & 15) : 4'h0;
      if (cap_dvb[i] === ex) m0++;
    end
    for (int i = 458; i < 912; i++) begin
      ex = (i < 714) ? 4'((i - 458) & 15) : 4'h0;
      if (cap_dvb[i] === ex) m1++;
    end
    checks++;
    if (m0 !== 456) begin
      errors++; $display("FAIL sat_half0: got %0d good want 456", m0);
    end
    checks++;
    if (m1 !== 454) begin
      errors++; $display("FAIL sat_half1: got %0d good want 454", m1);
    end
    checks++;
    if (cap_dvb[257] !== 4'hF || cap_dvb[258] !== 4'h0) begin
      errors++;
      $display("FAIL sat_edge: got %0h %0h want f 0", cap_dvb[257], cap_dvb[258]);
    end
    checks++;
    if (cap_hsb[457] !== 1'b1 || cap_dlb[457] !== 1'b1) begin
      errors++;
      $display("FAIL sat_half1_start: got %0b%0b want 11", cap_hsb[457], cap_dlb[457]);
    end
  endtask

  task automatic test_collision();
    int nr, r0, w0, r1, w1, m;
    logic [3:0] ex;
    // Short line: the next line_reset at offset 201 lands on a write strobe.
    tick(1'b1);
    repeat (200) tick(1'b0);
    run_line(912);
    scan_hs(912, nr, r0, w0, r1, w1);
    checks++;
    if (nr !== 2 || r0 !== 1 || r1 !== 101) begin
      errors++;
      $display("FAIL coll_sync: got n%0d r%0d r%0d want n2 r1 r101", nr, r0, r1);
    end
    m = 0;
    for (int i = 2; i < 912; i++) begin
      if (i < 102) ex = 4'((i - 2) & 15);
      else if (i < 202) ex = 4'((i - 102) & 15);
      else ex = 4'h0;
      if (cap_dv[i] === ex) m++;
    end
    checks++;
    if (m !== 910) begin
      errors++; $display("FAIL coll_pixels: got %0d good want 910", m);
    end
    checks++;
    if (cap_dv[201] !== 4'h3 || cap_dv[202] !== 4'h0) begin
      errors++;
      $display("FAIL coll_len: got %0h %0h want 3 0", cap_dv[201], cap_dv[202]);
    end
    run_line(912);
    checks++;
    if (cap_dv[2] !== 4'h0 || cap_dv[3] !== 4'h1) begin
      errors++;
      $display("FAIL coll_pix0: got %0h %0h want 0 1", cap_dv[2], cap_dv[3]);
    end
  endtask

  task automatic test_reset_mid();
    int nr, r0, w0, r1, w1, nz, m;
    tick(1'b1);
    repeat (469) tick(1'b0);
    checks++;
    if (hs_a !== 1'b1 || dl_a !== 1'b1 || dv_a !== 4'hC) begin
      errors++;
      $display("FAIL mid_before: got %0b %0b %0h want 1 1 c", hs_a, dl_a, dv_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (hs_a !== 1'b0 || dl_a !== 1'b0 || dv_a !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: got %0b %0b %0h want 0 0 0", hs_a, dl_a, dv_a);
    end
    @(posedge clk);
    #1;
    repeat (3) tick(1'b0);
    reset = 1'b0;
    repeat (20) tick(1'b0);
    run_line(912);
    scan_hs(912, nr, r0, w0, r1, w1);
    nz = 0;
    for (int i = 0; i < 912; i++) if (cap_dv[i] !== 4'h0) nz++;
    checks++;
    if (nz !== 0 || nr !== 1) begin
      errors++;
      $display("FAIL mid_first: got lit %0d pulses %0d want 0 1", nz, nr);
    end
    run_line(912);
    m = 0;
    for (int i = 2; i < 458; i++)
      if (cap_dv[i] === 4'((i - 2) & 15)) m++;
    checks++;
    if (m !== 456 || cap_dv[10] !== 4'h8) begin
      errors++;
      $display("FAIL mid_second: got %0d good px10 %0h want 456 8", m, cap_dv[10]);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_startup();
    test_basic();
    test_saturation();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
